// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared FSM state type, default geometry and index-width helper for wide_add_sequencer
package add_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W_DEF = 16;
    localparam int NUM_SLICES_DEF = 4;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/add_slice.sv
// add_slice: W-bit ripple-carry adder slice; ports a, b, cin -> sum, cout
module add_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_fa
            assign sum[i]  = a[i] ^ b[i] ^ c[i];
            assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate
    assign cout = c[W];
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: W-bit add done one SLICE_W slice per cycle, LSB slice first, with a registered carry.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_a/in_b/in_cin operand handshake;
// out_valid/out_ready/out_sum/out_cout result handshake; busy high while in RUN.
// Define ADD_SEQ_SUB_EN to add in_sub: subtract A-B (B inverted, carry-in forced to 1, in_cin ignored).
module wide_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int NUM_SLICES = NUM_SLICES_DEF,
    localparam int W         = SLICE_W * NUM_SLICES
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef ADD_SEQ_SUB_EN
    input  logic         in_sub,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);
    localparam int IW = idx_w(NUM_SLICES);
    state_t state;
    logic [IW-1:0] idx;
    logic carry;
    logic [W-1:0] a_r, b_r;
    logic [31:0] off;
    logic [SLICE_W-1:0] s_a, s_b, s_sum;
    logic s_cout, take, last, cin0;
`ifdef ADD_SEQ_SUB_EN
    logic sub_r;
    assign cin0 = in_sub | in_cin;
    assign s_b  = b_r[off +: SLICE_W] ^ {SLICE_W{sub_r}};
`else
    assign cin0 = in_cin;
    assign s_b  = b_r[off +: SLICE_W];
`endif
    assign off      = 32'(idx) * 32'(SLICE_W);
    assign s_a      = a_r[off +: SLICE_W];
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign take     = in_valid && in_ready;
    assign last     = idx == IW'(NUM_SLICES - 1);
    assign busy     = state == RUN;

    add_slice #(.W(SLICE_W)) u_slice (
        .a(s_a), .b(s_b), .cin(carry), .sum(s_sum), .cout(s_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_r     <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    out_sum[off +: SLICE_W] <= s_sum;
                    carry <= s_cout;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        out_cout  <= s_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: ;
            endcase
            // Accepting a request overrides the DONE->IDLE return, so handoff has no bubble.
            if (take) begin
                a_r   <= in_a;
                b_r   <= in_b;
                carry <= cin0;
                idx   <= '0;
                state <= RUN;
`ifdef ADD_SEQ_SUB_EN
                sub_r <= in_sub;
`endif
            end
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed self-checking bench for wide_add_sequencer
module tb_wide_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_cin = 1'b0;
    logic [63:0] in_a = '0, in_b = '0, out_sum;
    logic out_valid, out_ready = 1'b1, out_cout, busy;
`ifdef ADD_SEQ_SUB_EN
    logic in_sub = 1'b0;
`endif
    int n_vec = 0, n_err = 0;
    logic [63:0] held;

    always #5 clk = ~clk;

    wide_add_sequencer dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ADD_SEQ_SUB_EN
        .in_sub(in_sub),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin);
        int t = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        chk("accept_timeout", 64'(t < 20), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_result(input string tag, input logic [63:0] sum, input logic cout);
        int k = 0;
        while (!out_valid && k < 20) begin @(posedge clk); @(negedge clk); k++; end
        chk({tag, "_latency"}, 64'(k), 64'd4);
        chk({tag, "_sum"}, out_sum, sum);
        chk({tag, "_cout"}, 64'(out_cout), 64'(cout));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(64'h4, 64'h1, 1'b0);
        wait_result("add_small", 64'h5, 1'b0);
        @(negedge clk);
        chk("consumed_valid", 64'(out_valid), 64'd0);
        chk("consumed_ready", 64'(in_ready), 64'd1);

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_result("wrap", 64'h0, 1'b1);
        @(negedge clk);

        send(64'h0000_FFFF_0000_FFFF, 64'h1, 1'b1);
        wait_result("partial_ripple", 64'h0000_FFFF_0001_0001, 1'b0);
        @(negedge clk);

        out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        wait_result("bp", 64'h2345_6789_ABCD_F001, 1'b0);
        held = out_sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(out_valid), 64'd1);
            chk("bp_sum_stable", out_sum, held);
            chk("bp_cout_stable", 64'(out_cout), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b1; in_a = 64'h2; in_b = 64'h3; in_cin = 1'b0; out_ready = 1'b1;
        #1 chk("handoff_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("handoff_busy", 64'(busy), 64'd1);
        chk("handoff_valid_low", 64'(out_valid), 64'd0);
        wait_result("handoff", 64'h5, 1'b0);
        @(negedge clk);

        send(64'hAAAA, 64'h5555, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_sum_cleared", out_sum, 64'd0);
        begin
            logic seen = 1'b0;
            repeat (6) begin @(negedge clk); seen |= out_valid; end
            chk("abort_no_valid", 64'(seen), 64'd0);
        end

`ifdef ADD_SEQ_SUB_EN
        in_sub = 1'b1;
        send(64'h5, 64'h7, 1'b0);
        in_sub = 1'b0;
        wait_result("sub", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
